qspi_pad_ctrl: RTL and testbench
================================

Name: qspi_pad_ctrl

Overview:
- Parametrised pad-side adapter between the flash controller inside busmaster and the NLANES-wide serial-flash pins. Supports single-, quad- and octal-lane flash.
- Registers chip select, DDR clock pair, lane data and per-lane output enables.
- Inserts a bus turnaround, with a stall to the controller, whenever lanes switch from receive to drive.
- Returns read data captured a programmable number of cycles after each SCK rising edge, to absorb pad and flash round-trip delay.

Parameters:
- NLANES, 4: data lane count; legal values 1, 2, 4, 8.
- RDDELAY, 2: extra capture pipeline stages after the output register; 0..7.
- TURNAROUND, 1: all-Z cycles inserted on a receive-to-drive switch; 0..7. 0 disables turnaround.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_cs_n  in  1  controller chip select, active low.
- i_sck  in  2  DDR clock pair. [1] is the first half-cycle, [0] the second half-cycle.
- i_mod  in  2  lane mode. 0x selects SPI. 10 selects multi-lane out. 11 selects multi-lane in.
- i_dat  in  NLANES  controller output data.
- o_stall  out  1  controller must hold all inputs while high.
- o_rd_stb  out  1  o_rd_dat is valid this cycle.
- o_rd_dat  out  NLANES  captured read data.
- o_pad_cs_n  out  1  registered chip select.
- o_pad_sck  out  2  registered clock pair to the external DDR output cell.
- o_pad_dat  out  NLANES  registered lane output data.
- o_pad_oe  out  NLANES  per-lane output enable. 1 means drive.
- i_pad_dat  in  NLANES  lane pad inputs.

Behaviour:
- All pad outputs are registered. Latency from controller inputs to the pad is one cycle.
- Reset values:
  - o_pad_cs_n = 1, o_pad_sck = 2'b11, o_pad_dat = all ones.
  - o_pad_oe = SPI mask.
  - o_stall = 0, o_rd_stb = 0, o_rd_dat = 0.
  - State = DRIVE, turnaround counter = 0, strobe pipeline cleared.
- SPI mask:
  - Lane 0 driven from i_dat[0]. Lane 1 released (MISO).
  - Lanes 2 and 3 driven 1 (WP#, HOLD#). Lanes 4 and up released.
  - When NLANES < 4, lanes that do not exist are dropped.
- Mode 10: all lanes driven from i_dat. Mode 11: all lanes released, o_pad_dat = all ones.
- While i_cs_n is 1, the effective mode is SPI, regardless of i_mod.
- States:
  - DRIVE:
    - Target OE mask = mask(effective mode).
    - If the target sets any bit that is clear in the current o_pad_oe and TURNAROUND > 0, go to TURN and load counter = TURNAROUND.
    - Otherwise apply the target the next cycle.
    - Releasing lanes never triggers turnaround.
  - TURN:
    - o_pad_oe = current & target (newly driven lanes stay Z). o_pad_sck is held at 2'b11. o_stall = 1.
    - o_pad_cs_n still follows i_cs_n.
    - Counter decrements each cycle. At 1, return to DRIVE and apply the target the next cycle.
    - o_stall drops combinationally in the cycle the full target OE is registered.
  - If the target changes during TURN to one that needs no new lanes, abort to DRIVE immediately.
- Strobe on an SCK rising edge:
  - Source is the registered o_pad_sck value and its previous value prev.
  - Edge if sck == 2'b01, or if (prev[0] == 0 and sck[1] == 1).
  - Qualified only in cycles where lane 1 (SPI) or all lanes (mode 11) are released and o_pad_cs_n = 0.
- Capture:
  - The strobe enters an RDDELAY-deep shift register.
  - At the output of the shift register, i_pad_dat is registered into o_rd_dat and o_rd_stb pulses for one cycle.
  - Total latency from the registered edge cycle to o_rd_stb is RDDELAY+1.
  - In SPI mode o_rd_dat = {0..., i_pad_dat[1]}. In mode 11 o_rd_dat = i_pad_dat. The mode used is the one tagged with the strobe.
- Strobes already in flight complete even if cs_n rises or the mode changes.
- A synchronous reset mid-turnaround or mid-capture restores all reset values and drops pending strobes next cycle.

Test Plan:
1. Reset check: hold i_rst 2 cycles, then release.
   - Required: o_pad_cs_n = 1, o_pad_sck = 11, o_pad_oe = 4'b1101 (NLANES = 4), o_stall = 0, o_rd_stb = 0.
2. SPI drive: i_cs_n = 0, i_mod = 00, i_dat = 4'b0000, then 4'b0001.
   - Required: o_pad_dat = 4'b1110, then 4'b1111, each one cycle after the input.
   - Required: o_pad_oe = 1101 throughout.
3. Turnaround with TURNAROUND = 2: switch mode 11 to 10.
   - Required: o_stall high for exactly 2 cycles, o_pad_oe = 0000 and o_pad_sck = 11 during those cycles.
   - Required: o_pad_oe = 1111 on the third cycle.
   - Switch 10 to 11: OE = 0000 next cycle, no stall.
4. Read delay with RDDELAY = 2, mode 11: drive i_sck = 01 for one cycle and set i_pad_dat = 4'hA.
   - Required: o_rd_stb pulses exactly 3 cycles after o_pad_sck = 01, with o_rd_dat = 4'hA.
   - Repeat with i_sck = 00, then 11: the edge is detected on the 11 cycle.
5. cs_n release mid-TURN: raise i_cs_n during the first turnaround cycle (mode 11 to 10).
   - Required: target becomes SPI. Turnaround continues only if the SPI mask adds lanes; for a 0000-to-1101 switch it runs to completion.
   - Required: o_pad_cs_n = 1 one cycle after i_cs_n rises.
6. Reset mid-operation: assert i_rst during TURN, with a strobe pending in the pipeline.
   - Required: all outputs take their reset values next cycle, and no o_rd_stb occurs afterwards.

Source files
------------

// File: rtl/qspi_pad_ctrl.sv
// Pad-side adapter between the flash controller and the serial-flash pins:
// registers the pad outputs, inserts bus turnaround and captures delayed read data.
module qspi_pad_ctrl #(
    parameter int NLANES     = 4,
    parameter int RDDELAY    = 2,
    parameter int TURNAROUND = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cs_n,
    input  logic [1:0]        i_sck,
    input  logic [1:0]        i_mod,
    input  logic [NLANES-1:0] i_dat,
    output logic              o_stall,
    output logic              o_rd_stb,
    output logic [NLANES-1:0] o_rd_dat,
    output logic              o_pad_cs_n,
    output logic [1:0]        o_pad_sck,
    output logic [NLANES-1:0] o_pad_dat,
    output logic [NLANES-1:0] o_pad_oe,
    input  logic [NLANES-1:0] i_pad_dat
);

    localparam int         RDW  = (RDDELAY > 0) ? RDDELAY : 1;
    localparam int         MISO = (NLANES > 1) ? 1 : 0;
    localparam logic [2:0] TA   = 3'(TURNAROUND);

    typedef enum logic {ST_DRIVE = 1'b0, ST_TURN = 1'b1} state_t;

    function automatic logic [NLANES-1:0] spi_mask_f();
        logic [NLANES-1:0] m;
        for (int l = 0; l < NLANES; l++) begin
            m[l] = (l == 0) || (l == 2) || (l == 3);
        end
        return m;
    endfunction

    localparam logic [NLANES-1:0] SPI_MASK = spi_mask_f();

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic              cs_n_q;
    logic [1:0]        sck_q;
    logic              sck_prev0_q;
    logic [NLANES-1:0] dat_q;
    logic [NLANES-1:0] oe_q;
    logic              spi_q;
    logic              rx_q;
    logic              rd_stb_q;
    logic [NLANES-1:0] rd_dat_q;
    logic [NLANES-1:0] rd_dat_d;

    logic              eff_spi_s;
    logic              eff_rx_s;
    logic [NLANES-1:0] tgt_oe_s;
    logic [NLANES-1:0] tgt_dat_s;
    logic              adds_s;
    logic              sck_edge_s;
    logic              miso_rel_s;
    logic              rx_ok_s;
    logic              stb_s;
    logic              pipe_stb_s;
    logic              pipe_spi_s;

    // Effective mode and the lane pattern it asks for; cs_n high forces SPI.
    always_comb begin
        eff_spi_s = i_cs_n | ~i_mod[1];
        eff_rx_s  = ~eff_spi_s & i_mod[0];
        tgt_dat_s = '1;
        if (eff_spi_s) begin
            tgt_oe_s     = SPI_MASK;
            tgt_dat_s[0] = i_dat[0];
        end else if (eff_rx_s) begin
            tgt_oe_s = '0;
        end else begin
            tgt_oe_s  = '1;
            tgt_dat_s = i_dat;
        end
        adds_s = |(tgt_oe_s & ~oe_q);
    end

    // SCK rising edge seen on the registered clock pair, qualified by a released receive lane.
    always_comb begin
        sck_edge_s = (sck_q == 2'b01) | (~sck_prev0_q & sck_q[1]);
        miso_rel_s = (NLANES > 1) ? ~oe_q[MISO] : 1'b1;
        rx_ok_s    = spi_q ? miso_rel_s : (rx_q & ~(|oe_q));
        stb_s      = sck_edge_s & rx_ok_s & ~cs_n_q;
    end

    // Pad output registers and the drive/turnaround state machine.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_DRIVE;
            cnt_q       <= 3'd0;
            cs_n_q      <= 1'b1;
            sck_q       <= 2'b11;
            sck_prev0_q <= 1'b1;
            dat_q       <= '1;
            oe_q        <= SPI_MASK;
            spi_q       <= 1'b1;
            rx_q        <= 1'b0;
        end else begin
            cs_n_q      <= i_cs_n;
            dat_q       <= tgt_dat_s;
            sck_prev0_q <= sck_q[0];
            spi_q       <= eff_spi_s;
            rx_q        <= eff_rx_s;
            case (state_q)
                ST_DRIVE: begin
                    if (adds_s && (TA != 3'd0)) begin
                        state_q <= ST_TURN;
                        cnt_q   <= TA;
                        oe_q    <= oe_q & tgt_oe_s;
                        sck_q   <= 2'b11;
                    end else begin
                        oe_q  <= tgt_oe_s;
                        sck_q <= i_sck;
                    end
                end
                ST_TURN: begin
                    // A target that needs no new lanes ends the turnaround early.
                    if (!adds_s || (cnt_q == 3'd1)) begin
                        state_q <= ST_DRIVE;
                        cnt_q   <= 3'd0;
                        oe_q    <= tgt_oe_s;
                        sck_q   <= i_sck;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                        oe_q  <= oe_q & tgt_oe_s;
                        sck_q <= 2'b11;
                    end
                end
                default: begin
                    state_q <= ST_DRIVE;
                    cnt_q   <= 3'd0;
                    oe_q    <= SPI_MASK;
                    sck_q   <= 2'b11;
                end
            endcase
        end
    end

    generate
        if (RDDELAY == 0) begin : g_nodly
            assign pipe_stb_s = stb_s;
            assign pipe_spi_s = spi_q;
        end else begin : g_dly
            logic [RDW-1:0] stb_sr_q;
            logic [RDW-1:0] spi_sr_q;
            // Round-trip delay line for the strobe and the mode it was taken in.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    stb_sr_q <= '0;
                    spi_sr_q <= '0;
                end else begin
                    stb_sr_q[0] <= stb_s;
                    spi_sr_q[0] <= spi_q;
                    for (int i = 1; i < RDW; i++) begin
                        stb_sr_q[i] <= stb_sr_q[i-1];
                        spi_sr_q[i] <= spi_sr_q[i-1];
                    end
                end
            end
            assign pipe_stb_s = stb_sr_q[RDW-1];
            assign pipe_spi_s = spi_sr_q[RDW-1];
        end
    endgenerate

    // Read data selection: single MISO bit in SPI, full lane word otherwise.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if (pipe_stb_s) begin
            if (pipe_spi_s) begin
                rd_dat_d    = '0;
                rd_dat_d[0] = i_pad_dat[MISO];
            end else begin
                rd_dat_d = i_pad_dat;
            end
        end else begin
            rd_dat_d = rd_dat_q;
        end
    end

    // Read strobe and captured data registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_stb_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            rd_stb_q <= pipe_stb_s;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign o_stall    = (state_q == ST_TURN);
    assign o_rd_stb   = rd_stb_q;
    assign o_rd_dat   = rd_dat_q;
    assign o_pad_cs_n = cs_n_q;
    assign o_pad_sck  = sck_q;
    assign o_pad_dat  = dat_q;
    assign o_pad_oe   = oe_q;

endmodule

// File: tb/tb_qspi_pad_ctrl.sv
// Bench for qspi_pad_ctrl (4 lanes, RDDELAY 2, TURNAROUND 2): cycle model plus literal spot checks.
module tb_qspi_pad_ctrl;

    localparam int NL  = 4;
    localparam int RDD = 2;
    localparam int TA  = 2;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_cs_n;
    logic [1:0]    i_sck;
    logic [1:0]    i_mod;
    logic [NL-1:0] i_dat;
    logic [NL-1:0] i_pad_dat;
    logic          o_stall;
    logic          o_rd_stb;
    logic [NL-1:0] o_rd_dat;
    logic          o_pad_cs_n;
    logic [1:0]    o_pad_sck;
    logic [NL-1:0] o_pad_dat;
    logic [NL-1:0] o_pad_oe;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model state: what each pad output must be after the next edge.
    logic       m_cs_n, m_stall, m_stb, m_prev0, m_spi, m_rx;
    logic [1:0] m_sck;
    logic [3:0] m_dat, m_oe, m_rd;
    int         m_turn;
    int         due_q[$];
    bit         tag_q[$];

    qspi_pad_ctrl #(.NLANES(NL), .RDDELAY(RDD), .TURNAROUND(TA)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_cs_n(i_cs_n), .i_sck(i_sck), .i_mod(i_mod),
        .i_dat(i_dat), .o_stall(o_stall), .o_rd_stb(o_rd_stb), .o_rd_dat(o_rd_dat),
        .o_pad_cs_n(o_pad_cs_n), .o_pad_sck(o_pad_sck), .o_pad_dat(o_pad_dat),
        .o_pad_oe(o_pad_oe), .i_pad_dat(i_pad_dat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Advance one clock: predict from the inputs, clock the DUT, compare every output.
    task automatic step();
        logic       spi, rx, edge_hit, qual;
        logic [3:0] t_oe, t_dat, newl;
        spi   = i_cs_n || !i_mod[1];
        rx    = !spi && i_mod[0];
        t_oe  = spi ? 4'b1101 : (rx ? 4'b0000 : 4'b1111);
        t_dat = spi ? {3'b111, i_dat[0]} : (rx ? 4'b1111 : i_dat);
        newl  = t_oe & ~m_oe;
        edge_hit = (m_sck == 2'b01) || (!m_prev0 && m_sck[1]);
        qual     = !m_cs_n && (m_spi ? !m_oe[1] : (m_rx && (m_oe == 4'b0000)));
        if (i_rst) begin
            m_cs_n = 1'b1; m_sck = 2'b11; m_dat = 4'b1111; m_oe = 4'b1101;
            m_stall = 1'b0; m_stb = 1'b0; m_rd = 4'b0000; m_prev0 = 1'b1;
            m_spi = 1'b1; m_rx = 1'b0; m_turn = 0;
            due_q.delete();
            tag_q.delete();
        end else begin
            if (edge_hit && qual) begin
                due_q.push_back(cyc + RDD + 1);
                tag_q.push_back(m_spi);
            end
            m_stb = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
                m_stb = 1'b1;
                m_rd  = tag_q[0] ? {3'b000, i_pad_dat[1]} : i_pad_dat;
                void'(due_q.pop_front());
                void'(tag_q.pop_front());
            end
            if (m_turn == 0) begin
                if (newl != 4'b0000 && TA > 0) m_turn = TA;
            end else if (newl == 4'b0000) begin
                m_turn = 0;
            end else begin
                m_turn = m_turn - 1;
            end
            m_prev0 = m_sck[0];
            if (m_turn > 0) begin
                m_oe = m_oe & t_oe; m_sck = 2'b11; m_stall = 1'b1;
            end else begin
                m_oe = t_oe; m_sck = i_sck; m_stall = 1'b0;
            end
            m_cs_n = i_cs_n;
            m_dat  = t_dat;
            m_spi  = spi;
            m_rx   = rx;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("pad_cs_n", 32'(o_pad_cs_n), 32'(m_cs_n));
        chk("pad_sck",  32'(o_pad_sck),  32'(m_sck));
        chk("pad_dat",  32'(o_pad_dat),  32'(m_dat));
        chk("pad_oe",   32'(o_pad_oe),   32'(m_oe));
        chk("stall",    32'(o_stall),    32'(m_stall));
        chk("rd_stb",   32'(o_rd_stb),   32'(m_stb));
        chk("rd_dat",   32'(o_rd_dat),   32'(m_rd));
    endtask

    initial begin
        i_rst = 1'b1; i_cs_n = 1'b1; i_sck = 2'b11; i_mod = 2'b00;
        i_dat = 4'h0; i_pad_dat = 4'h0;
        step(); step();
        i_rst = 1'b0;
        chk("lit_rst_cs_n", 32'(o_pad_cs_n), 32'd1);
        chk("lit_rst_sck",  32'(o_pad_sck),  32'd3);
        chk("lit_rst_oe",   32'(o_pad_oe),   32'hD);
        chk("lit_rst_stall", 32'(o_stall),   32'd0);
        chk("lit_rst_stb",  32'(o_rd_stb),   32'd0);

        // SPI drive
        i_cs_n = 1'b0; i_mod = 2'b00; i_dat = 4'b0000;
        step();
        chk("lit_spi_dat0", 32'(o_pad_dat), 32'hE);
        chk("lit_spi_oe",   32'(o_pad_oe),  32'hD);
        i_dat = 4'b0001;
        step();
        chk("lit_spi_dat1", 32'(o_pad_dat), 32'hF);

        // Release all lanes, then turnaround into multi-lane out
        i_mod = 2'b11;
        step();
        chk("lit_rel_oe", 32'(o_pad_oe), 32'h0);
        chk("lit_rel_stall", 32'(o_stall), 32'd0);
        i_mod = 2'b10;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("lit_turn_stall", 32'(o_stall), 32'd1);
            chk("lit_turn_oe", 32'(o_pad_oe), 32'h0);
            chk("lit_turn_sck", 32'(o_pad_sck), 32'd3);
        end
        step();
        chk("lit_turn_done_stall", 32'(o_stall), 32'd0);
        chk("lit_turn_done_oe", 32'(o_pad_oe), 32'hF);
        i_mod = 2'b11;
        step();
        chk("lit_back_oe", 32'(o_pad_oe), 32'h0);
        chk("lit_back_stall", 32'(o_stall), 32'd0);

        // Abort a turnaround by returning to receive
        i_mod = 2'b10;
        step();
        i_mod = 2'b11;
        step();
        chk("lit_abort_stall", 32'(o_stall), 32'd0);

        // Read capture: single 01 pulse
        i_sck = 2'b01; i_pad_dat = 4'hA;
        step();
        chk("lit_edge_sck", 32'(o_pad_sck), 32'd1);
        i_sck = 2'b11;
        step(); step();
        chk("lit_rd_early", 32'(o_rd_stb), 32'd0);
        step();
        chk("lit_rd_stb", 32'(o_rd_stb), 32'd1);
        chk("lit_rd_dat", 32'(o_rd_dat), 32'hA);
        step();
        chk("lit_rd_once", 32'(o_rd_stb), 32'd0);

        // Read capture: 00 then 11
        i_pad_dat = 4'h5; i_sck = 2'b00;
        step();
        i_sck = 2'b11;
        step(); step(); step(); step();
        chk("lit_rd2_stb", 32'(o_rd_stb), 32'd1);
        chk("lit_rd2_dat", 32'(o_rd_dat), 32'h5);

        // SPI read after a receive-to-drive turnaround
        i_mod = 2'b00;
        step(); step(); step();
        chk("lit_spi_back_oe", 32'(o_pad_oe), 32'hD);
        i_sck = 2'b01; i_pad_dat = 4'b0010;
        step();
        i_sck = 2'b11;
        step(); step(); step();
        chk("lit_spi_rd", 32'(o_rd_dat), 32'h1);

        // cs_n rises during the first turnaround cycle
        i_mod = 2'b11;
        step();
        i_mod = 2'b10;
        step();
        i_cs_n = 1'b1;
        step();
        chk("lit_csn_stall", 32'(o_stall), 32'd1);
        chk("lit_csn_pad", 32'(o_pad_cs_n), 32'd1);
        step();
        chk("lit_csn_oe", 32'(o_pad_oe), 32'hD);
        chk("lit_csn_done", 32'(o_stall), 32'd0);

        // Reset during turnaround with a strobe in flight
        i_cs_n = 1'b0; i_mod = 2'b11;
        step();
        i_sck = 2'b01;
        step();
        i_sck = 2'b11; i_mod = 2'b10;
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("lit_mrst_cs_n", 32'(o_pad_cs_n), 32'd1);
        chk("lit_mrst_oe", 32'(o_pad_oe), 32'hD);
        chk("lit_mrst_stall", 32'(o_stall), 32'd0);
        chk("lit_mrst_rd_dat", 32'(o_rd_dat), 32'h0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("lit_mrst_no_stb", 32'(o_rd_stb), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
